// File: rtl/sipo_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx_pkg
// Description : Shared types and helpers for the SIPO receive controller.
//               Provides the controller state encoding and the bit-counter
//               width function used to size bit_cnt.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_rx_pkg;

  // Controller states. PARITY is only reachable when PARITY_CHECK_EN is
  // defined at build time.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_e;

  // Width of the per-word bit counter. The counter only has to hold
  // 0..WIDTH-1, because it wraps to 0 on the bit that completes a word.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : sipo_rx_pkg
`default_nettype wire

// File: rtl/sipo_shreg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shreg
// Description : WIDTH-bit serial-in / parallel-out shift register. Shifts
//               toward the MSB so the first bit received ends up at the MSB
//               after WIDTH shifts. Content is never cleared between words.
// Ports       : clk       - clock
//               rst_n     - asynchronous active-low reset
//               shift_en  - shift serial_in in on this clock edge
//               serial_in - serial data bit
//               par_out   - current register content
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] r_shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
    end else if (shift_en) begin
      r_shreg <= {r_shreg[WIDTH-2:0], serial_in};
    end
  end

  assign par_out = r_shreg;

endmodule : sipo_shreg
`default_nettype wire

// File: rtl/sipo_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx_ctrl
// Description : Framing controller for a serial-in/parallel-out receive path.
//               Gates shifting, counts bits per word, handles resync, captures
//               completed words into a holding register with a valid/ready
//               handshake and flags overrun when the consumer stalls.
// Build macro : PARITY_CHECK_EN - when defined, each word is followed by an
//               even-parity bit; capture happens on the parity-bit cycle and
//               the sticky par_err output is present.
// Ports       : clk          - clock
//               rst_n        - asynchronous active-low reset
//               en           - block enable, low forces IDLE
//               sync         - frame-start strobe (same-cycle bit is bit 0)
//               serial_in    - serial data bit
//               serial_valid - serial_in qualifier
//               out_data     - captured word, first-received bit at MSB
//               out_valid    - out_data holds an unconsumed word
//               out_ready    - consumer accepts out_data
//               bit_cnt      - bits received in the current partial word
//               busy         - FSM is receiving (SHIFT or PARITY)
//               overrun      - sticky, a completed word was dropped
//               ovr_clr      - clears overrun (and par_err)
//               par_err      - sticky parity error (PARITY_CHECK_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter bit SYNC_RESTART = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         sync,
  input  logic                         serial_in,
  input  logic                         serial_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [cnt_width(WIDTH)-1:0]  bit_cnt,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         ovr_clr
`ifdef PARITY_CHECK_EN
  ,
  output logic                         par_err
`endif
);

  localparam int                 c_CNT_W    = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  rx_state_e           r_state;
  rx_state_e           w_state_nxt;
  logic [c_CNT_W-1:0]  r_bit_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_valid;
  logic                r_overrun;
  logic [WIDTH-1:0]    w_shreg;
  logic [WIDTH-1:0]    w_cap_word;
  logic                w_shift_en;
  logic                w_capture;
  logic                w_ovr_set;
  logic                w_load;

  // --------------------------------------------------------------------------
  // Shift path
  // --------------------------------------------------------------------------
  sipo_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (w_shift_en),
    .serial_in (serial_in),
    .par_out   (w_shreg)
  );

`ifdef PARITY_CHECK_EN
  logic w_par_bad;
  logic r_par_err;
`else
  // Without parity the completed word is formed combinationally from the
  // register plus the bit arriving this cycle, so the old MSB drops out.
  logic w_unused_msb;
  assign w_unused_msb = w_shreg[WIDTH-1];
`endif

  // --------------------------------------------------------------------------
  // FSM state register and bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, shift gating and capture strobe
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_en  = 1'b0;
    w_capture   = 1'b0;
`ifdef PARITY_CHECK_EN
    w_cap_word  = w_shreg;
    w_par_bad   = 1'b0;
`else
    w_cap_word  = {w_shreg[WIDTH-2:0], serial_in};
`endif

    if (!en) begin
      // Disable drops the partial word; the holding register is untouched.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sync) begin
            w_state_nxt = SHIFT;
            w_shift_en  = serial_valid;
            w_cnt_nxt   = serial_valid ? c_CNT_ONE : '0;
          end
        end

        SHIFT: begin
          if (SYNC_RESTART && sync) begin
            // Resync beats word completion: no capture, count restarts
            // with the sync-cycle bit as bit 0.
            w_shift_en = serial_valid;
            w_cnt_nxt  = serial_valid ? c_CNT_ONE : '0;
          end else if (serial_valid) begin
            w_shift_en = 1'b1;
            if (r_bit_cnt == c_CNT_LAST) begin
              w_cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
              w_state_nxt = PARITY;
`else
              w_capture   = 1'b1;
`endif
            end else begin
              w_cnt_nxt = r_bit_cnt + c_CNT_ONE;
            end
          end
        end

`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (SYNC_RESTART && sync) begin
            w_state_nxt = SHIFT;
            w_shift_en  = serial_valid;
            w_cnt_nxt   = serial_valid ? c_CNT_ONE : '0;
          end else if (serial_valid) begin
            // The parity bit is not shifted in; the register already holds
            // the complete word. Even parity: word XOR parity bit must be 0.
            w_capture   = 1'b1;
            w_par_bad   = (^w_shreg) ^ serial_in;
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
          end
        end
`endif

        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Holding register, handshake and sticky flags
  // --------------------------------------------------------------------------
  // A completed word is loaded when the holding register is free or is being
  // consumed on this same edge; otherwise it is dropped and flagged.
  assign w_load    = w_capture && (!r_out_valid || out_ready);
  assign w_ovr_set = w_capture && r_out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= w_cap_word;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Set has priority over clear on a coincident cycle.
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (w_capture && w_par_bad) begin
      r_par_err <= 1'b1;
    end else if (ovr_clr) begin
      r_par_err <= 1'b0;
    end
  end

  assign par_err = r_par_err;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign bit_cnt   = r_bit_cnt;
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;

endmodule : sipo_rx_ctrl
`default_nettype wire

// File: tb/tb_sipo_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_rx_ctrl
// Description : Directed self-checking bench for sipo_rx_ctrl (WIDTH=16,
//               SYNC_RESTART=1). Words expected to reach the consumer are
//               queued when sent and compared when the handshake completes.
//               Build with PARITY_CHECK_EN to exercise the parity variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_rx_ctrl;

  localparam int c_W = 16;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           sync;
  logic           serial_in;
  logic           serial_valid;
  logic [c_W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     bit_cnt;
  logic           busy;
  logic           overrun;
  logic           ovr_clr;
`ifdef PARITY_CHECK_EN
  logic           par_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [c_W-1:0] sb_q[$];

  sipo_rx_ctrl #(
    .WIDTH        (c_W),
    .SYNC_RESTART (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sync         (sync),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .bit_cnt      (bit_cnt),
    .busy         (busy),
    .overrun      (overrun),
    .ovr_clr      (ovr_clr)
`ifdef PARITY_CHECK_EN
    ,
    .par_err      (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic s);
    serial_in    = b;
    serial_valid = 1'b1;
    sync         = s;
    step();
    serial_valid = 1'b0;
    sync         = 1'b0;
  endtask

  task automatic send_bits(input logic [c_W-1:0] w, input int hi, input int lo, input bit sync_first);
    for (int i = hi; i >= lo; i--) begin
      drive_bit(w[i], sync_first && (i == hi));
    end
  endtask

  // Tail of a word: parity bit when built with parity, nothing otherwise.
  task automatic finish_word(input logic [c_W-1:0] w);
`ifdef PARITY_CHECK_EN
    drive_bit(^w, 1'b0);
`else
    if (w === 'x) step();
`endif
  endtask

  task automatic send_word(input logic [c_W-1:0] w, input bit sync_first,
                           input bit gaps, input bit ready_last);
    for (int i = c_W - 1; i >= 0; i--) begin
      if (gaps && (i % 3 == 1)) step();
`ifndef PARITY_CHECK_EN
      if (ready_last && i == 0) out_ready = 1'b1;
`endif
      drive_bit(w[i], sync_first && (i == c_W - 1));
    end
`ifdef PARITY_CHECK_EN
    if (ready_last) out_ready = 1'b1;
    drive_bit(^w, 1'b0);
`endif
  endtask

  // Consumer side: every accepted word must be the oldest queued one.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      assert (sb_q.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected: observed word 0x%0h expected none", out_data);
      end
      if (sb_q.size() > 0) chk("sb_word", out_data, sb_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; serial_in = 1'b0;
    serial_valid = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
`ifdef PARITY_CHECK_EN
    chk("rst_par_err", par_err, 0);
`endif
    rst_n = 1'b1;
    en    = 1'b1;
    step();

    // Single word, consumer ready
    out_ready = 1'b1;
    sb_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1'b1, 1'b0, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 16'hA5C3);
    chk("t1_bit_cnt", bit_cnt, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_valid_one_cycle", out_valid, 0);

    // Back-to-back words with gaps, consumer stalled -> overrun
    out_ready = 1'b0;
    sb_q.push_back(16'h1234);
    send_word(16'h1234, 1'b0, 1'b1, 1'b0);
    chk("t2_no_ovr_yet", overrun, 0);
    send_word(16'hFFFF, 1'b0, 1'b1, 1'b0);
    chk("t2_data_kept", out_data, 16'h1234);
    chk("t2_valid", out_valid, 1);
    chk("t2_overrun", overrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t2_ovr_clr", overrun, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_drained", out_valid, 0);

    // Accept and load on the same edge is not an overrun
    sb_q.push_back(16'h00FF);
    send_word(16'h00FF, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(16'hAAAA);
    send_word(16'hAAAA, 1'b0, 1'b0, 1'b1);
    chk("t3_data", out_data, 16'hAAAA);
    chk("t3_valid", out_valid, 1);
    chk("t3_overrun", overrun, 0);
    step();
    chk("t3_drained", out_valid, 0);

    // Resync mid-word restarts the count at the sync bit
    send_bits(16'h00FE, 6, 0, 1'b1);
    chk("t4_partial_cnt", bit_cnt, 7);
    sb_q.push_back(16'h5A5A);
    send_bits(16'h5A5A, 15, 15, 1'b1);
    chk("t4_restart_cnt", bit_cnt, 1);
    send_bits(16'h5A5A, 14, 0, 1'b0);
    finish_word(16'h5A5A);
    chk("t4_data", out_data, 16'h5A5A);
    chk("t4_valid", out_valid, 1);
    step();

    // Disable mid-word, then restart with sync
    send_bits(16'h01FF, 8, 0, 1'b1);
    chk("t5_partial_cnt", bit_cnt, 9);
    en = 1'b0;
    step();
    chk("t5_dis_cnt", bit_cnt, 0);
    chk("t5_dis_busy", busy, 0);
    en = 1'b1;
    sb_q.push_back(16'h0F0F);
    send_word(16'h0F0F, 1'b1, 1'b0, 1'b0);
    chk("t5_data", out_data, 16'h0F0F);
    step();

    // Asynchronous reset mid-word with a word pending
    out_ready = 1'b0;
    send_word(16'hC3C3, 1'b0, 1'b0, 1'b0);
    send_bits(16'hFFFF, 4, 0, 1'b0);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_cnt", bit_cnt, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_data", out_data, 0);
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_cnt", bit_cnt, 0);
    chk("t6_async_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    step();

`ifdef PARITY_CHECK_EN
    // Parity error is captured anyway, sticky, cleared by ovr_clr
    out_ready = 1'b1;
    sb_q.push_back(16'h0001);
    send_bits(16'h0001, 15, 0, 1'b1);
    drive_bit(1'b0, 1'b0);
    chk("t7_data", out_data, 16'h0001);
    chk("t7_par_err", par_err, 1);
    sb_q.push_back(16'h0003);
    send_bits(16'h0003, 15, 0, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("t7_data2", out_data, 16'h0003);
    chk("t7_par_sticky", par_err, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t7_par_clr", par_err, 0);
    step();
`endif

    chk("sb_all_consumed", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sipo_rx_ctrl
`default_nettype wire
